// File: rtl/mux_nto1_pipe.sv
// N-to-1 channel select feeding a two-entry skid buffer (head + skid) with
// valid/ready on both sides. All outputs come straight from registers.
module mux_nto1_pipe #(
  parameter int size     = 32,
  parameter int channels = 4,
  parameter int sel_w    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [channels*size-1:0] data_i,
  input  logic [sel_w-1:0]         select_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [size-1:0]          data_o,
  output logic                     sel_err_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic                     flush_i,
  output logic [1:0]               occ_o
);

  generate
    if (channels < 2 || channels > 16 || (2 ** sel_w) < channels) begin : g_bad_params
      $error("mux_nto1_pipe: channels must be 2..16 and fit in sel_w bits");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready is a pure register decode.
  // The state encoding doubles as the occupancy count.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]      r_state;
  logic [size-1:0] r_head_data;
  logic [size-1:0] r_skid_data;
  logic            r_head_err;
  logic            r_skid_err;

  logic [size-1:0] w_new_data;
  logic            w_new_err;
  logic            w_push;
  logic            w_pop;

  // Out-of-range selects capture zero data and flag the entry.
  always_comb begin
    w_new_data = '0;
    w_new_err  = (int'(select_i) >= channels);
    for (int k = 0; k < channels; k++) begin
      if (int'(select_i) == k) w_new_data = data_i[k*size +: size];
    end
  end

  assign ready_o   = (r_state != S_FULL);
  assign valid_o   = (r_state != S_EMPTY);
  assign occ_o     = r_state;
  assign data_o    = r_head_data;
  assign sel_err_o = r_head_err;

  assign w_push = valid_i & ready_o;
  assign w_pop  = valid_o & ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_EMPTY;
      r_head_data <= '0;
      r_head_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else if (flush_i) begin
      // Head keeps its last value so data_o holds while empty.
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_head_data <= w_new_data;
            r_head_err  <= w_new_err;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            r_head_data <= w_new_data;
            r_head_err  <= w_new_err;
          end else if (w_push) begin
            r_skid_data <= w_new_data;
            r_skid_err  <= w_new_err;
            r_state     <= S_FULL;
          end else if (w_pop) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            r_head_data <= r_skid_data;
            r_head_err  <= r_skid_err;
            r_state     <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: a 4-channel and a 3-channel instance share stimulus
// and are compared against a queue-based FIFO model.
module tb_mux_nto1_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] data_in = '0;
  logic [1:0]   sel_in = '0;
  logic         valid_in = 1'b0;
  logic         ready_in = 1'b0;
  logic         flush = 1'b0;

  logic        ready4, err4, valid4;
  logic [31:0] data4;
  logic [1:0]  occ4;
  logic        ready3, err3, valid3;
  logic [31:0] data3;
  logic [1:0]  occ3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [127:0] d;
    logic [1:0]   s;
  } ent_t;

  ent_t mq[$];
  ent_t hold;

  always #5 clk = ~clk;

  mux_nto1_pipe #(.size(32), .channels(4), .sel_w(2)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .data_i(data_in), .select_i(sel_in),
    .valid_i(valid_in), .ready_o(ready4), .data_o(data4), .sel_err_o(err4),
    .valid_o(valid4), .ready_i(ready_in), .flush_i(flush), .occ_o(occ4)
  );

  mux_nto1_pipe #(.size(32), .channels(3), .sel_w(2)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .data_i(data_in[95:0]), .select_i(sel_in),
    .valid_i(valid_in), .ready_o(ready3), .data_o(data3), .sel_err_o(err3),
    .valid_o(valid3), .ready_i(ready_in), .flush_i(flush), .occ_o(occ3)
  );

  function automatic logic [31:0] pick(logic [127:0] d, logic [1:0] s, int ch);
    if (int'(s) >= ch) return 32'h0;
    return d[int'(s)*32 +: 32];
  endfunction

  task automatic model_reset();
    mq.delete();
    hold.d = '0;
    hold.s = '0;
  endtask

  // Advance one clock edge and update the model with the inputs presented.
  task automatic step();
    bit   push, pop;
    ent_t e;
    push = valid_in && (mq.size() < 2);
    pop  = (mq.size() > 0) && ready_in;
    e.d  = data_in;
    e.s  = sel_in;
    @(posedge clk);
    #1;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    if (mq.size() > 0) hold = mq[0];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #3;
    checks++;
    if ({valid4, occ4, err4, data4} !== 36'h0) begin
      errors++;
      $display("FAIL reset_async4: got v=%b occ=%0d err=%b d=%h expected all zero", valid4, occ4, err4, data4);
    end
    checks++;
    if ({ready4, ready3} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 11", {ready4, ready3});
    end
    @(posedge clk); #1;
    checks++;
    if ({valid3, occ3, err3, data3} !== 36'h0) begin
      errors++;
      $display("FAIL reset_held3: got v=%b occ=%0d err=%b d=%h expected all zero", valid3, occ3, err3, data3);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_select();
    data_in  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    sel_in   = 2'd2;
    valid_in = 1'b1;
    ready_in = 1'b1;
    step();
    checks++;
    if ({data4, data3} !== {32'h33333333, 32'h33333333}) begin
      errors++;
      $display("FAIL select_ch2: got %h/%h expected 33333333/33333333", data4, data3);
    end
    checks++;
    if ({valid4, err4, occ4, err3} !== {1'b1, 1'b0, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL select_flags: got v=%b e4=%b occ=%0d e3=%b expected v=1 e4=0 occ=1 e3=0", valid4, err4, occ4, err3);
    end
    sel_in = 2'd3;
    step();
    checks++;
    if ({data4, err4} !== {32'h44444444, 1'b0}) begin
      errors++;
      $display("FAIL select_ch3_4ch: got %h err=%b expected 44444444 err=0", data4, err4);
    end
    checks++;
    if ({data3, err3, occ3} !== {32'h0, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL select_oor_3ch: got %h err=%b occ=%0d expected 00000000 err=1 occ=1", data3, err3, occ3);
    end
    valid_in = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    ready_in = 1'b0;
    valid_in = 1'b1;
    sel_in   = 2'd0;
    data_in  = {4{32'hA}};
    step();
    data_in  = {4{32'hB}};
    step();
    data_in  = {4{32'hC}};
    checks++;
    if ({occ4, ready4, occ3, ready3} !== {2'd2, 1'b0, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL b2b_full: got occ=%0d rdy=%b expected occ=2 rdy=0", occ4, ready4);
    end
    step();
    checks++;
    if ({occ4, data4} !== {2'd2, 32'hA}) begin
      errors++;
      $display("FAIL b2b_hold: got occ=%0d d=%h expected occ=2 d=0000000a", occ4, data4);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    checks++;
    if ({occ4, valid4, data4} !== {2'd1, 1'b1, 32'hB}) begin
      errors++;
      $display("FAIL b2b_pop1: got occ=%0d v=%b d=%h expected occ=1 v=1 d=0000000b", occ4, valid4, data4);
    end
    step();
    checks++;
    if ({occ4, valid4, ready4} !== {2'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_pop2: got occ=%0d v=%b rdy=%b expected occ=0 v=0 rdy=1", occ4, valid4, ready4);
    end
  endtask

  task automatic test_push_pop_same();
    ready_in = 1'b0;
    valid_in = 1'b1;
    sel_in   = 2'd1;
    data_in  = {4{32'h5}};
    step();
    data_in  = {4{32'h6}};
    ready_in = 1'b1;
    step();
    checks++;
    if ({data4, occ4} !== {32'h6, 2'd1}) begin
      errors++;
      $display("FAIL pushpop: got d=%h occ=%0d expected d=00000006 occ=1", data4, occ4);
    end
    ready_in = 1'b0;
    data_in  = {4{32'h7}};
    step();
    flush    = 1'b1;
    data_in  = {4{32'h8}};
    step();
    flush    = 1'b0;
    valid_in = 1'b0;
    checks++;
    if ({occ4, valid4, ready4, occ3, valid3} !== {2'd0, 1'b0, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL flush_full: got occ=%0d v=%b rdy=%b expected occ=0 v=0 rdy=1", occ4, valid4, ready4);
    end
    step();
    checks++;
    if ({occ4, valid4, data4} !== {2'd0, 1'b0, 32'h6}) begin
      errors++;
      $display("FAIL flush_drop: got occ=%0d v=%b d=%h expected occ=0 v=0 d=00000006", occ4, valid4, data4);
    end
  endtask

  task automatic test_reset_mid();
    ready_in = 1'b0;
    valid_in = 1'b1;
    sel_in   = 2'd0;
    data_in  = {4{32'h1}};
    step();
    data_in  = {4{32'h2}};
    step();
    valid_in = 1'b0;
    checks++;
    if (occ4 !== 2'd2) begin
      errors++;
      $display("FAIL rstmid_fill: got occ=%0d expected 2", occ4);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid4, occ4, data4, valid3, occ3, data3} !== 70'h0) begin
      errors++;
      $display("FAIL rstmid_clear: got v=%b occ=%0d d=%h expected v=0 occ=0 d=00000000", valid4, occ4, data4);
    end
    model_reset();
    #2 rst = 1'b0;
    valid_in = 1'b1;
    ready_in = 1'b1;
    data_in  = {4{32'h7}};
    step();
    valid_in = 1'b0;
    checks++;
    if ({data4, valid4, occ4} !== {32'h7, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL rstmid_push: got d=%h v=%b occ=%0d expected d=00000007 v=1 occ=1", data4, valid4, occ4);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] e4, e3;
    logic        ee3;
    for (int i = 0; i < 400; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      sel_in   = 2'($urandom_range(0, 3));
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      step();
      e4  = pick(hold.d, hold.s, 4);
      e3  = pick(hold.d, hold.s, 3);
      ee3 = (hold.s == 2'd3);
      checks++;
      if ({occ4, valid4, ready4} !== {2'(mq.size()), mq.size() > 0, mq.size() < 2}) begin
        errors++;
        $display("FAIL rand_ctrl4 #%0d: got occ=%0d v=%b r=%b expected occ=%0d", i, occ4, valid4, ready4, mq.size());
      end
      checks++;
      if ({occ3, valid3, ready3} !== {occ4, valid4, ready4}) begin
        errors++;
        $display("FAIL rand_ctrl3 #%0d: got occ=%0d expected occ=%0d", i, occ3, mq.size());
      end
      checks++;
      if ({data4, err4} !== {e4, 1'b0}) begin
        errors++;
        $display("FAIL rand_data4 #%0d: got %h err=%b expected %h err=0", i, data4, err4, e4);
      end
      checks++;
      if ({data3, err3} !== {e3, ee3}) begin
        errors++;
        $display("FAIL rand_data3 #%0d: got %h err=%b expected %h err=%b", i, data3, err3, e3, ee3);
      end
    end
    valid_in = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_select();
    test_back_to_back();
    test_push_pop_same();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

endmodule
